// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bundle: decode/execute hazard sources in,
// pipeline register enables, flushes, status flags and counters out.
interface pipeline_hazard_ctrl_if;
    logic [3:0]  rs_d;
    logic [3:0]  rt_d;
    logic        uses_rs_d;
    logic        uses_rt_d;
    logic        mem_read_de;
    logic [3:0]  rd_de;
    logic        branch_taken_d;
    logic        hlt_d;
    logic        mem_req_xm;
    logic        mem_ready;
    logic        pc_wen;
    logic        fd_wen;
    logic        fd_flush;
    logic        de_wen;
    logic        de_flush;
    logic        xm_wen;
    logic        mw_wen;
    logic        halted;
    logic        mem_timeout;
    logic [15:0] stall_cnt;
    logic [15:0] freeze_cnt;

    modport master (
        output rs_d, rt_d, uses_rs_d, uses_rt_d, mem_read_de, rd_de,
        output branch_taken_d, hlt_d, mem_req_xm, mem_ready,
        input  pc_wen, fd_wen, fd_flush, de_wen, de_flush, xm_wen, mw_wen,
        input  halted, mem_timeout, stall_cnt, freeze_cnt
    );

    modport slave (
        input  rs_d, rt_d, uses_rs_d, uses_rt_d, mem_read_de, rd_de,
        input  branch_taken_d, hlt_d, mem_req_xm, mem_ready,
        output pc_wen, fd_wen, fd_flush, de_wen, de_flush, xm_wen, mw_wen,
        output halted, mem_timeout, stall_cnt, freeze_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, load-use stall, branch flush
// and HLT drain. Ports: clk, rst (sync, active-high), bus (slave modport).
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, DRAIN, HALTED} state_e;

    state_e      state_q, state_d;
    logic [1:0]  drain_cnt_q, drain_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] freeze_cnt_q, freeze_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic freeze;
    logic load_use;
    logic pc_wen, fd_wen, fd_flush, de_wen, de_flush, xm_wen, mw_wen;

    assign freeze = bus.mem_req_xm & ~bus.mem_ready;

    // Register 0 is hardwired, so a load into it never creates a hazard.
    assign load_use = bus.mem_read_de & (bus.rd_de != 4'd0) &
                      ((bus.uses_rs_d & (bus.rs_d == bus.rd_de)) |
                       (bus.uses_rt_d & (bus.rt_d == bus.rd_de)));

    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        freeze_cnt_d  = freeze_cnt_q;
        mem_timeout_d = mem_timeout_q;
        pc_wen        = 1'b0;
        fd_wen        = 1'b0;
        fd_flush      = 1'b0;
        de_wen        = 1'b0;
        de_flush      = 1'b0;
        xm_wen        = 1'b0;
        mw_wen        = 1'b0;
        if (!rst) begin
            if (state_q != HALTED && freeze) begin
                // Whole pipe holds; a long enough wait is treated as a hang.
                wait_cnt_d   = wait_cnt_q + 8'd1;
                freeze_cnt_d = (freeze_cnt_q == 16'hFFFF) ?
                               freeze_cnt_q : freeze_cnt_q + 16'd1;
                if (wait_cnt_q == 8'hFF) begin
                    state_d       = HALTED;
                    mem_timeout_d = 1'b1;
                end else if (state_q != DRAIN) begin
                    state_d = MEM_WAIT;
                end
            end else begin
                wait_cnt_d = 8'd0;
                unique case (state_q)
                    RUN, MEM_WAIT: begin
                        state_d  = RUN;
                        pc_wen   = 1'b1;
                        fd_wen   = 1'b1;
                        de_wen   = 1'b1;
                        xm_wen   = 1'b1;
                        mw_wen   = 1'b1;
                        if (load_use) begin
                            pc_wen      = 1'b0;
                            fd_wen      = 1'b0;
                            de_flush    = 1'b1;
                            stall_cnt_d = (stall_cnt_q == 16'hFFFF) ?
                                          stall_cnt_q : stall_cnt_q + 16'd1;
                        end else if (bus.branch_taken_d) begin
                            fd_flush = 1'b1;
                        end else if (bus.hlt_d) begin
                            pc_wen      = 1'b0;
                            fd_flush    = 1'b1;
                            state_d     = DRAIN;
                            drain_cnt_d = 2'd3;
                        end
                    end
                    DRAIN: begin
                        // Feed bubbles behind the HLT until the pipe is empty.
                        fd_wen      = 1'b1;
                        fd_flush    = 1'b1;
                        de_wen      = 1'b1;
                        de_flush    = 1'b1;
                        xm_wen      = 1'b1;
                        mw_wen      = 1'b1;
                        drain_cnt_d = drain_cnt_q - 2'd1;
                        if (drain_cnt_q == 2'd1) begin
                            state_d = HALTED;
                        end
                    end
                    HALTED: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= RUN;
            drain_cnt_q   <= 2'd0;
            wait_cnt_q    <= 8'd0;
            stall_cnt_q   <= 16'd0;
            freeze_cnt_q  <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            freeze_cnt_q  <= freeze_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign bus.pc_wen      = pc_wen;
    assign bus.fd_wen      = fd_wen;
    assign bus.fd_flush    = fd_flush;
    assign bus.de_wen      = de_wen;
    assign bus.de_flush    = de_flush;
    assign bus.xm_wen      = xm_wen;
    assign bus.mw_wen      = mw_wen;
    assign bus.halted      = (state_q == HALTED);
    assign bus.mem_timeout = mem_timeout_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.freeze_cnt  = freeze_cnt_q;
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk input 1 (rising-edge clock); rst input 1 (synchronous, active-high reset).
REQ-002 SHALL have inputs: rs_d 4, rt_d 4 (decode source regs); uses_rs_d 1, uses_rt_d 1 (decode reads rs/rt); mem_read_de 1, rd_de 4 (decode/execute stage load and its destination).
REQ-003 SHALL have inputs: branch_taken_d 1 (decode resolved taken branch); hlt_d 1 (HLT in decode); mem_req_xm 1 (execute/memory stage data-memory access); mem_ready 1 (data memory completes this cycle).
REQ-004 SHALL have outputs: pc_wen, fd_wen, fd_flush, de_wen, de_flush, xm_wen, mw_wen, each 1 bit (pipeline register enables; flush = load NOP/bubble at this edge).
REQ-005 SHALL have outputs: halted 1, mem_timeout 1, stall_cnt 16, freeze_cnt 16 (saturating performance counters).

Function
REQ-006 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED, plus a 2-bit drain_cnt and an 8-bit wait_cnt.
REQ-007 freeze SHALL be mem_req_xm & ~mem_ready, evaluated in RUN, MEM_WAIT and DRAIN.
REQ-008 load_use SHALL be mem_read_de & (rd_de != 0) & ((uses_rs_d & rs_d == rd_de) | (uses_rt_d & rt_d == rd_de)); register 0 never causes a hazard.
REQ-009 Priority SHALL be: HALTED > freeze > load_use > branch_taken_d > hlt_d.
REQ-010 freeze: all seven wen = 0, flushes = 0, state -> MEM_WAIT (or stays DRAIN), wait_cnt += 1, freeze_cnt += 1.
REQ-011 Leaving freeze (mem_ready = 1) SHALL zero wait_cnt and return MEM_WAIT -> RUN on the same edge; outputs that cycle follow the RUN rules.
REQ-012 freeze with wait_cnt == 255 SHALL transition to HALTED and set mem_timeout = 1 (sticky until rst).
REQ-013 load_use (RUN, no freeze): pc_wen = 0, fd_wen = 0, de_wen = 1, de_flush = 1, xm_wen = mw_wen = 1, stall_cnt += 1; exactly one bubble per hazard.
REQ-014 branch_taken_d (RUN, no freeze, no load_use): all wen = 1, fd_flush = 1.
REQ-015 hlt_d (RUN, no higher-priority event): pc_wen = 0, fd_flush = 1, other wen = 1; state -> DRAIN, drain_cnt loaded with 3.
REQ-016 DRAIN: pc_wen = 0, fd_flush = 1, de/xm/mw wen = 1, de_flush = 1; hlt_d and branch_taken_d ignored.
REQ-017 DRAIN: each unfrozen cycle SHALL decrement drain_cnt; an unfrozen cycle with drain_cnt == 1 SHALL transition to HALTED (HALTED is reached 3 unfrozen cycles after DRAIN entry).
REQ-018 HALTED: all wen = 0, flushes = 0, halted = 1; HALTED is exited only by rst.
REQ-019 RUN with no event: all wen = 1, flushes = 0.
REQ-020 halted SHALL be 1 exactly when state == HALTED.
REQ-021 Counters SHALL saturate at 16'hFFFF and never wrap.
REQ-022 All outputs other than counters/flags SHALL be combinational from state and inputs; there SHALL be no registered-output latency.

Reset
REQ-023 rst = 1 at an edge SHALL set state = RUN, drain_cnt = 0, wait_cnt = 0, stall_cnt = 0, freeze_cnt = 0, mem_timeout = 0, halted = 0.
REQ-024 While rst = 1, all wen and flush outputs SHALL be 0.
REQ-025 rst asserted in any state, including mid-DRAIN or mid-MEM_WAIT, SHALL return the block to RUN on the next edge with all counters cleared.

Verification
REQ-026 Load-use: mem_read_de = 1, rd_de = 5, rs_d = 5, uses_rs_d = 1 -> one cycle of pc_wen = 0, fd_wen = 0, de_flush = 1; stall_cnt = 1; next cycle (mem_read_de = 0) all wen = 1.
REQ-027 R0 and no-use cases: rd_de = 0 with rs_d = 0, or rt_d match with uses_rt_d = 0 -> no stall, stall_cnt stays 0.
REQ-028 Freeze: mem_req_xm = 1, mem_ready = 0 for 4 cycles, then 1 -> all wen = 0 for 4 cycles, freeze_cnt = 4, state back to RUN, wait_cnt = 0; with load_use also asserted, freeze wins.
REQ-029 Halt: hlt_d = 1 in RUN with no freeze -> pc_wen = 0 and fd_flush = 1 from that cycle; halted = 1 after 3 further edges. With a 2-cycle freeze injected during DRAIN -> halted = 1 after 5 further edges.
REQ-030 Timeout: mem_ready held 0 with mem_req_xm = 1 for 256 cycles -> HALTED, mem_timeout = 1, freeze_cnt = 256.
REQ-031 Reset: rst asserted during DRAIN and again during HALTED -> next cycle state = RUN, halted = 0, all counters 0; simultaneous branch_taken_d and load_use -> load_use response only.
